// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the clock-gating controller: FSM state encoding and
// default wake-up / idle timing constants used by the system top-level.
package clk_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int unsigned DEF_WAKE_CYC = 2;
    localparam int unsigned DEF_IDLE_CYC = 4;
    localparam int unsigned DEF_CNT_W    = 4;

endpackage

// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller for a latch-based gating cell: clk_en one edge after req, ack WAKE_CYC edges later,
// clk_en drops after IDLE_CYC idle edges in HOLD; test_en forces the enable on combinationally.
module clk_gate_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned WAKE_CYC = DEF_WAKE_CYC,
    parameter int unsigned IDLE_CYC = DEF_IDLE_CYC,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               busy,
    input  logic               test_en,
    output logic               clk_en,
    output logic               ack,
    output logic               sleep_pls,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nxt;
    logic             en_r, en_nxt;
    logic             ack_r, ack_nxt;
    logic             sleep_r, sleep_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic wake_cond;
    logic idle_cond;

    assign wake_cond = req | test_en;
    assign idle_cond = !req && !busy && !test_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OFF;
            en_r    <= 1'b0;
            ack_r   <= 1'b0;
            sleep_r <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            en_r    <= en_nxt;
            ack_r   <= ack_nxt;
            sleep_r <= sleep_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        en_nxt    = en_r;
        ack_nxt   = ack_r;
        sleep_nxt = 1'b0;
        cnt_nxt   = cnt;
        unique case (state)
            OFF: begin
                en_nxt  = 1'b0;
                ack_nxt = 1'b0;
                if (wake_cond) begin
                    state_nxt = WAKE;
                    en_nxt    = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            // WAKE never aborts, so the enable is never a runt pulse.
            WAKE: begin
                en_nxt  = 1'b1;
                ack_nxt = 1'b0;
                if (cnt == WAKE_LAST) begin
                    state_nxt = ON;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ON: begin
                en_nxt  = 1'b1;
                ack_nxt = 1'b1;
                if (idle_cond) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                en_nxt  = 1'b1;
                ack_nxt = 1'b1;
                // A new request beats the terminal count: the clock keeps running.
                if (!idle_cond) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                end else if (cnt == IDLE_LAST) begin
                    state_nxt = OFF;
                    en_nxt    = 1'b0;
                    ack_nxt   = 1'b0;
                    sleep_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = OFF;
        endcase
    end

    assign clk_en    = en_r | test_en;
    assign ack       = ack_r;
    assign sleep_pls = sleep_r;
    assign state_o   = state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: a vector table for wake/sleep plus hand sequences for multi-cycle corners.
module tb_clk_gate_ctrl;

    logic       clk;
    logic       rst;
    logic       req;
    logic       busy;
    logic       test_en;
    logic       clk_en;
    logic       ack;
    logic       sleep_pls;
    logic [1:0] state_o;

    int n_cmp;
    int n_bad;

    clk_gate_ctrl #(
        .WAKE_CYC (2),
        .IDLE_CYC (4),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .busy      (busy),
        .test_en   (test_en),
        .clk_en    (clk_en),
        .ack       (ack),
        .sleep_pls (sleep_pls),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic       busy;
        logic       te;
        logic       en;
        logic       ack;
        logic       sp;
        logic [1:0] st;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic e, input logic a,
                           input logic s, input logic [1:0] st);
        chk({nm, "_clk_en"}, int'(clk_en), int'(e));
        chk({nm, "_ack"}, int'(ack), int'(a));
        chk({nm, "_sleep"}, int'(sleep_pls), int'(s));
        chk({nm, "_state"}, int'(state_o), int'(st));
    endtask

    vec_t vecs [14];

    initial begin
        int en_cnt;
        int ack_cnt;
        int on_cnt;
        int sp_cnt;

        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        req     = 1'b0;
        busy    = 1'b0;
        test_en = 1'b0;

        //          req   busy  te    en    ack   sp    st
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1}; // E0: enable up
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1}; // E0+1: still waking
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2}; // E0+2: ack
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3}; // F0: HOLD
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3}; // F0+3
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}; // F0+4: gated off
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // pulse cleared
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // busy alone: no wake
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1}; // req wakes, busy ignored
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2};

        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        step();
        chk_all("post_reset", 1'b0, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < 14; i++) begin
            req     = vecs[i].req;
            busy    = vecs[i].busy;
            test_en = vecs[i].te;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].ack, vecs[i].sp, vecs[i].st);
        end

        // Re-request at HOLD cnt=2, then again at the terminal count.
        req  = 1'b0;
        busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("rereq_hold%0d", k), 1'b1, 1'b1, 1'b0, 2'd3);
        end
        req = 1'b1;
        step();
        chk_all("rereq_on", 1'b1, 1'b1, 1'b0, 2'd2);
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_all($sformatf("tc_hold%0d", k), 1'b1, 1'b1, 1'b0, 2'd3);
        end
        req = 1'b1;
        step();
        chk_all("tc_req_wins", 1'b1, 1'b1, 1'b0, 2'd2);
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_all($sformatf("resleep_hold%0d", k), 1'b1, 1'b1, 1'b0, 2'd3);
        end
        step();
        chk_all("resleep_off", 1'b0, 1'b0, 1'b1, 2'd0);
        step();
        chk_all("resleep_clr", 1'b0, 1'b0, 1'b0, 2'd0);

        // Busy keeps the clock running in ON.
        req = 1'b1;
        step();
        step();
        step();
        chk("busy_on_state", int'(state_o), 2);
        req  = 1'b0;
        busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_all($sformatf("busy%0d", k), 1'b1, 1'b1, 1'b0, 2'd2);
        end
        busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_all($sformatf("busy_hold%0d", k), 1'b1, 1'b1, 1'b0, 2'd3);
        end
        step();
        chk_all("busy_off", 1'b0, 1'b0, 1'b1, 2'd0);

        // One-cycle request pulse from OFF.
        step();
        en_cnt  = 0;
        ack_cnt = 0;
        on_cnt  = 0;
        sp_cnt  = 0;
        req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            req = 1'b0;
            if (clk_en)        en_cnt++;
            if (ack)           ack_cnt++;
            if (state_o == 2)  on_cnt++;
            if (sleep_pls)     sp_cnt++;
        end
        chk("pulse_en_cycles", en_cnt, 7);
        chk("pulse_ack_cycles", ack_cnt, 5);
        chk("pulse_on_cycles", on_cnt, 1);
        chk("pulse_sleep_cnt", sp_cnt, 1);
        chk("pulse_final_state", int'(state_o), 0);

        // test_en forces the enable combinationally and wakes the FSM.
        test_en = 1'b1;
        #1;
        chk("te_comb_en", int'(clk_en), 1);
        chk("te_comb_state", int'(state_o), 0);
        step();
        chk_all("te_wake", 1'b1, 1'b0, 1'b0, 2'd1);
        step();
        step();
        chk_all("te_on", 1'b1, 1'b1, 1'b0, 2'd2);
        test_en = 1'b0;
        step();
        step();
        chk_all("pre_rst_hold", 1'b1, 1'b1, 1'b0, 2'd3);

        // Asynchronous reset in the middle of HOLD.
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 2'd0);
        test_en = 1'b1;
        #1;
        chk("rst_te_en", int'(clk_en), 1);
        test_en = 1'b0;
        #1;
        chk("rst_te_off", int'(clk_en), 0);
        step();
        rst = 1'b0;
        step();
        chk_all("rst_release", 1'b0, 1'b0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
